alu_driver16: RTL and testbench
===============================

ALU_DRIVER16 -- requirements
Module: alu_driver16

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1: command offered.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_op, input, 4: 16-bit operation code, same encoding as the 8-bit ALU op.
REQ-007 SHALL have ports cmd_a and cmd_b, input, 16 each: operands.
REQ-008 SHALL have port cmd_carry, input, 1: carry/borrow-in for ops 1, 3, 14, 15.
REQ-009 SHALL have ports alu_a and alu_b, output, 8 each: byte operands driven to the 8-bit ALU.
REQ-010 SHALL have ports alu_op, output, 4, and alu_carry, output, 1: op and carry driven to the ALU.
REQ-011 SHALL have ports alu_c, input, 8, alu_carry_out, input, 1, and alu_zero, input, 1: combinational ALU results.
REQ-012 SHALL have ports res_valid, output, 1, and res_ready, input, 1: result handshake.
REQ-013 SHALL have ports res_data, output, 16, res_carry, output, 1, and res_zero, output, 1: result and flags.
REQ-014 SHALL have port op_count, output, CNT_W: number of results consumed.

Function
REQ-015 SHALL implement FSM IDLE -> PASS1 -> PASS2 -> DONE -> IDLE; cmd_ready=1 only in IDLE; res_valid=1 only in DONE.
REQ-016 SHALL capture cmd_op, cmd_a, cmd_b and cmd_carry on acceptance; cmd_valid outside IDLE is ignored.
REQ-017 SHALL drive the ALU combinationally from state and captured operands, and register alu_c/alu_carry_out at the end of each pass; in IDLE and DONE it drives alu_op=0, alu_a=alu_b=0, alu_carry=0.
REQ-018 SHALL, for ops 0-3, run PASS1 on the low bytes with op 0/1/2/3 (carry=cmd_carry for 1/3, else 0), then PASS2 on the high bytes with op 1 (for 0/1) or op 3 (for 2/3), alu_carry = PASS1 carry_out.
REQ-019 SHALL, for ops 4-8, apply the same ALU op to the low bytes then the high bytes; res_carry=0.
REQ-020 SHALL, for ops 9-11, perform a 16-bit a-b using op 2 low then op 3 high, with result 16'hFFFF if borrow, 16'h0000 if difference is 0, else 16'h0001; res_carry=borrow.
REQ-021 SHALL, for ops 12/13, use op 12 on the low byte then op 14 on the high byte with alu_carry = low carry_out; for op 14, use op 14 on both, low carry-in = cmd_carry.
REQ-022 SHALL, for op 15, process the high byte first (op 15, carry=cmd_carry) and then the low byte (op 15, carry = high carry_out).
REQ-023 SHALL set res_carry to the carry_out of the second pass (except per REQ-019/020) and res_zero = (res_data == 0).
REQ-024 SHALL give fixed latency: command accepted at edge N gives res_valid high from edge N+3.
REQ-025 SHALL hold res_data/res_carry/res_zero stable while res_valid && !res_ready; on res_valid && res_ready it returns to IDLE and increments op_count, wrapping modulo 2^CNT_W.
REQ-026 SHALL permit no overlap: a new command is accepted no earlier than the cycle after the result handshake.

Reset
REQ-027 SHALL, when resetn=0 at a clock edge, enter IDLE and clear res_data, res_carry, res_zero, res_valid and op_count to 0; cmd_ready=1 from the next cycle.
REQ-028 SHALL abort any in-flight operation on reset mid-PASS1/PASS2/DONE without producing a result or incrementing op_count.

Verification
REQ-029 SHALL verify op 0 with a=0x00FF, b=0x0001 -> res_data=0x0100, carry=0, zero=0; a=0xFFFF, b=0x0001 -> 0x0000, carry=1, zero=1.
REQ-030 SHALL verify op 2 with a=0x0100, b=0x0001 -> 0x00FF, carry=0; a=0x0000, b=0x0001 -> 0xFFFF, carry=1.
REQ-031 SHALL verify op 15 with a=0x0001, cmd_carry=1 -> 0x8000, carry=1; op 12 with a=0x8080 -> 0x0100, carry=1.
REQ-032 SHALL verify op 11 with 0x1234 vs 0x1234 -> 0x0000, zero=1, carry=0; 0x1233 vs 0x1234 -> 0xFFFF, carry=1.
REQ-033 SHALL verify res_ready held low 5 cycles -> res_valid and result stable, cmd_ready=0, and a second cmd_valid is ignored; op_count increments once on handshake.
REQ-034 SHALL verify resetn low during PASS2 -> next cycle IDLE, res_valid=0, op_count unchanged at 0.

Source files
------------

// File: rtl/alu_driver16.sv
// Sequences a 16-bit operation as two passes through an external 8-bit ALU.
// It captures the command, drives the ALU one byte per pass and presents the result with a valid/ready handshake.
module alu_driver16 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic             cmd_carry,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_carry,
  input  logic [7:0]       alu_c,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        carry_q;
  logic [7:0]  p1_c;
  logic        p1_carry, p1_zero;
  logic        hi_first, logic_op, cmp_op;
  logic [15:0] word, data_next;
  logic        carry_next;

  // Rotate-right walks from the high byte down so the carry flows the right way.
  assign hi_first  = (op_q == 4'd15);
  assign logic_op  = (op_q >= 4'd4) && (op_q <= 4'd8);
  assign cmp_op    = (op_q >= 4'd9) && (op_q <= 4'd11);
  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = PASS1;
      PASS1:   state_next = PASS2;
      PASS2:   state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_op    = 4'd0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_carry = 1'b0;
    case (state)
      PASS1: begin
        alu_a = hi_first ? a_q[15:8] : a_q[7:0];
        alu_b = hi_first ? b_q[15:8] : b_q[7:0];
        case (op_q)
          4'd9, 4'd10, 4'd11: alu_op = 4'd2;
          4'd12, 4'd13:       alu_op = 4'd12;
          default:            alu_op = op_q;
        endcase
        case (op_q)
          4'd1, 4'd3, 4'd14, 4'd15: alu_carry = carry_q;
          default:                  alu_carry = 1'b0;
        endcase
      end
      PASS2: begin
        alu_a = hi_first ? a_q[7:0] : a_q[15:8];
        alu_b = hi_first ? b_q[7:0] : b_q[15:8];
        case (op_q)
          4'd0, 4'd1:                     alu_op = 4'd1;
          4'd2, 4'd3, 4'd9, 4'd10, 4'd11: alu_op = 4'd3;
          4'd12, 4'd13, 4'd14:            alu_op = 4'd14;
          default:                        alu_op = op_q;
        endcase
        alu_carry = logic_op ? 1'b0 : p1_carry;
      end
      default: ;
    endcase
  end

  // Compare ops reduce the 16-bit difference to -1/0/+1 using both byte zero flags.
  always_comb begin
    word       = hi_first ? {p1_c, alu_c} : {alu_c, p1_c};
    data_next  = word;
    carry_next = alu_carry_out;
    if (logic_op) begin
      carry_next = 1'b0;
    end else if (cmp_op) begin
      if (alu_carry_out)
        data_next = 16'hFFFF;
      else if (p1_zero && alu_zero)
        data_next = 16'h0000;
      else
        data_next = 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      op_q      <= 4'd0;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      carry_q   <= 1'b0;
      p1_c      <= 8'd0;
      p1_carry  <= 1'b0;
      p1_zero   <= 1'b0;
      res_data  <= 16'd0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      op_count  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && cmd_valid) begin
        op_q    <= cmd_op;
        a_q     <= cmd_a;
        b_q     <= cmd_b;
        carry_q <= cmd_carry;
      end
      if (state == PASS1) begin
        p1_c     <= alu_c;
        p1_carry <= alu_carry_out;
        p1_zero  <= alu_zero;
      end
      if (state == PASS2) begin
        res_data  <= data_next;
        res_carry <= carry_next;
        res_zero  <= (data_next == 16'd0);
      end
      if (state == DONE && res_ready)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_driver16.sv
// Bench for alu_driver16: models the 8-bit ALU as a responder and checks every result
// against a whole-word reference model computed directly from 16-bit arithmetic.
module tb_alu_driver16;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_carry;
  logic [7:0]  alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic        alu_carry, alu_carry_out, alu_zero;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_carry, res_zero;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expCount = 16'd0;

  alu_driver16 #(.CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_carry(cmd_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry(alu_carry),
    .alu_c(alu_c), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU: add/adc, sub/sbb, and/or/xor/not/nand, shift-left, rotate-left/right through carry.
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    case (alu_op)
      4'd0:  t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:  t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry};
      4'd2:  t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd3:  t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_carry};
      4'd4:  t = {1'b0, alu_a & alu_b};
      4'd5:  t = {1'b0, alu_a | alu_b};
      4'd6:  t = {1'b0, alu_a ^ alu_b};
      4'd7:  t = {1'b0, ~alu_a};
      4'd8:  t = {1'b0, ~(alu_a & alu_b)};
      4'd12: t = {alu_a[7], alu_a[6:0], 1'b0};
      4'd14: t = {alu_a[7], alu_a[6:0], alu_carry};
      4'd15: t = {alu_a[0], alu_carry, alu_a[7:1]};
      default: t = 9'd0;
    endcase
    alu_c         = t[7:0];
    alu_carry_out = t[8];
    alu_zero      = (t[7:0] == 8'd0);
  end

  // Whole-word reference: returns {carry, data}.
  function automatic logic [16:0] refModel(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
    logic [16:0] r;
    case (op)
      4'd0:  r = {1'b0, a} + {1'b0, b};
      4'd1:  r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      4'd2:  r = {1'b0, a} - {1'b0, b};
      4'd3:  r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      4'd4:  r = {1'b0, a & b};
      4'd5:  r = {1'b0, a | b};
      4'd6:  r = {1'b0, a ^ b};
      4'd7:  r = {1'b0, ~a};
      4'd8:  r = {1'b0, ~(a & b)};
      4'd9, 4'd10, 4'd11:
        r = (a < b) ? {1'b1, 16'hFFFF} : (a == b) ? 17'd0 : 17'd1;
      4'd12, 4'd13: r = {a[15], a[14:0], 1'b0};
      4'd14: r = {a[15], a[14:0], cin};
      default: r = {a[0], cin, a[15:1]};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full transaction: accept, fixed latency, optional back-pressure with an intruding command, handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input int holdCycles, input bit intrude);
    logic [16:0] exp;
    exp = refModel(op, a, b, cin);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_carry = cin; res_ready = 1'b0;
    checkOutput("idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0; cmd_carry = 1'b0;
    checkOutput("busy_ready", cmd_ready, 0);
    checkOutput("early_valid1", res_valid, 0);
    @(negedge clk);
    checkOutput("early_valid2", res_valid, 0);
    // After edge N+2 the result is visible, so the consumer sees it at edge N+3.
    @(negedge clk);
    checkOutput("valid", res_valid, 1);
    checkOutput("data", res_data, {16'd0, exp[15:0]});
    checkOutput("carry", res_carry, exp[16]);
    checkOutput("zero", res_zero, exp[15:0] == 16'd0);
    for (int i = 0; i < holdCycles; i++) begin
      if (intrude) begin
        cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a; cmd_b = b ^ 16'h5A5A; cmd_carry = ~cin;
      end
      @(negedge clk);
      checkOutput("hold_valid", res_valid, 1);
      checkOutput("hold_ready", cmd_ready, 0);
      checkOutput("hold_data", res_data, {16'd0, exp[15:0]});
      checkOutput("hold_carry", res_carry, exp[16]);
      checkOutput("hold_count", op_count, expCount);
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    expCount = expCount + 16'd1;
    checkOutput("post_valid", res_valid, 0);
    checkOutput("post_ready", cmd_ready, 1);
    checkOutput("count", op_count, expCount);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
    cmd_carry = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", res_valid, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_count", op_count, 0);
    checkOutput("rst_data", res_data, 0);
    resetn = 1'b1;

    // Abort an operation while it is in its second pass.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'h1234; cmd_b = 16'h1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("abort_valid", res_valid, 0);
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_count", op_count, 0);
    repeat (3) @(negedge clk);
    checkOutput("abort_still_idle", res_valid, 0);

    applyStimulus(4'd0,  16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    applyStimulus(4'd0,  16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    applyStimulus(4'd2,  16'h0100, 16'h0001, 1'b0, 0, 1'b0);
    applyStimulus(4'd2,  16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    applyStimulus(4'd15, 16'h0001, 16'h0000, 1'b1, 0, 1'b0);
    applyStimulus(4'd12, 16'h8080, 16'h0000, 1'b0, 0, 1'b0);
    applyStimulus(4'd11, 16'h1234, 16'h1234, 1'b0, 0, 1'b0);
    applyStimulus(4'd11, 16'h1233, 16'h1234, 1'b0, 0, 1'b0);
    applyStimulus(4'd1,  16'h7FFF, 16'h0000, 1'b1, 5, 1'b1);
    applyStimulus(4'd14, 16'h4080, 16'h0000, 1'b1, 1, 1'b0);

    for (int n = 0; n < 40; n++)
      applyStimulus(4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
